// File: rtl/ascon_perm_scheduler.sv
// Round-robin scheduler sharing one Ascon permutation core between two requesters.
// Loads the winner's state, steps the core round by round, and returns the result.
module ascon_perm_scheduler #(
  parameter int MAX_ROUNDS = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [319:0] req0_state,
  input  logic [4:0]   req0_rounds,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [319:0] req1_state,
  input  logic [4:0]   req1_rounds,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [319:0] rsp_state,
  output logic [319:0] perm_state,
  output logic [4:0]   perm_ctr,
  output logic [4:0]   perm_rounds,
  output logic         perm_start,
  input  logic [319:0] perm_out,
  input  logic         perm_done,
  output logic         busy
);

  localparam logic [4:0] MAX_R = 5'(MAX_ROUNDS);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, CAPT, RESP} state_e;

  state_e         state_q, state_d;
  logic           rr_q, rr_d;
  logic           owner_q, owner_d;
  logic [319:0]   perm_state_q, perm_state_d;
  logic [319:0]   rsp_state_q, rsp_state_d;
  logic [4:0]     perm_rounds_q, perm_rounds_d;
  logic [4:0]     perm_ctr_q, perm_ctr_d;
  logic           perm_start_q, perm_start_d;
  logic           rsp0_valid_q, rsp0_valid_d;
  logic           rsp1_valid_q, rsp1_valid_d;
  logic           busy_q, busy_d;

  logic           grant0, grant1;
  logic [4:0]     sel_rounds, clamped_rounds;

  // Ties go to the requester named by rr; ready is masked while reset is asserted.
  always_comb begin
    grant0         = req0_valid & (~req1_valid | ~rr_q);
    grant1         = req1_valid & (~req0_valid | rr_q);
    req0_ready     = reset & (state_q == IDLE) & grant0;
    req1_ready     = reset & (state_q == IDLE) & grant1;
    sel_rounds     = grant1 ? req1_rounds : req0_rounds;
    clamped_rounds = ((sel_rounds == 5'd0) || (sel_rounds > MAX_R)) ? MAX_R : sel_rounds;
  end

  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    owner_d       = owner_q;
    perm_state_d  = perm_state_q;
    rsp_state_d   = rsp_state_q;
    perm_rounds_d = perm_rounds_q;
    perm_ctr_d    = perm_ctr_q;
    perm_start_d  = perm_start_q;
    rsp0_valid_d  = rsp0_valid_q;
    rsp1_valid_d  = rsp1_valid_q;

    case (state_q)
      IDLE: begin
        if (req0_ready || req1_ready) begin
          owner_d       = grant1;
          perm_state_d  = grant1 ? req1_state : req0_state;
          perm_rounds_d = clamped_rounds;
          perm_ctr_d    = 5'd0;
          perm_start_d  = 1'b1;
          state_d       = LOAD;
        end
      end
      LOAD: begin
        perm_ctr_d   = 5'd1;
        perm_start_d = 1'b1;
        state_d      = RUN;
      end
      RUN: begin
        if (perm_ctr_q == perm_rounds_q) begin
          perm_ctr_d   = 5'd0;
          perm_start_d = 1'b0;
          state_d      = CAPT;
        end else begin
          perm_ctr_d = perm_ctr_q + 5'd1;
        end
      end
      CAPT: begin
        // A missing done simply parks here; a correct core never lets that happen.
        if (perm_done) begin
          rsp_state_d  = perm_out;
          rsp0_valid_d = ~owner_q;
          rsp1_valid_d = owner_q;
          state_d      = RESP;
        end
      end
      RESP: begin
        if ((owner_q & rsp1_ready) | (~owner_q & rsp0_ready)) begin
          rsp0_valid_d = 1'b0;
          rsp1_valid_d = 1'b0;
          rr_d         = ~owner_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      rr_q          <= 1'b0;
      owner_q       <= 1'b0;
      perm_state_q  <= '0;
      rsp_state_q   <= '0;
      perm_rounds_q <= '0;
      perm_ctr_q    <= '0;
      perm_start_q  <= 1'b0;
      rsp0_valid_q  <= 1'b0;
      rsp1_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_q          <= rr_d;
      owner_q       <= owner_d;
      perm_state_q  <= perm_state_d;
      rsp_state_q   <= rsp_state_d;
      perm_rounds_q <= perm_rounds_d;
      perm_ctr_q    <= perm_ctr_d;
      perm_start_q  <= perm_start_d;
      rsp0_valid_q  <= rsp0_valid_d;
      rsp1_valid_q  <= rsp1_valid_d;
      busy_q        <= busy_d;
    end
  end

  assign perm_state  = perm_state_q;
  assign perm_rounds = perm_rounds_q;
  assign perm_ctr    = perm_ctr_q;
  assign perm_start  = perm_start_q;
  assign rsp_state   = rsp_state_q;
  assign rsp0_valid  = rsp0_valid_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign busy        = busy_q;

endmodule
